pp_param_loader: RTL and testbench

Per-layer configuration controller for the postprocessor. On a start pulse from top, it waits until the postprocessor has drained. It then pulls one scale word and the packed per-output-channel biases from the AXI read stream, writes the biases into the postprocessor's bias buffer, and holds the scale. Finally it raises a ready flag that gates postprocessing of PE results for that layer.

---
 rtl/pp_param_loader_pkg.sv | 26 ++
 rtl/pp_param_loader.sv | 201 ++++++++++++++++++++
 tb/tb_pp_param_loader.sv | 444 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pp_param_loader_pkg.sv
// Shared definitions for the postprocessor parameter loader: controller state
// encodings, default data widths and the bias packing factor of a stream word.
package pp_param_loader_pkg;

  // Default widths; the loader exposes these as overridable parameters.
  localparam int PP_W_CHANNEL  = 10;
  localparam int PP_BIAS_DW    = 16;
  localparam int PP_SCALES_DW  = 32;
  localparam int PP_AXI_DW     = 32;

  // Layer index width carried from the top-level sequencer.
  localparam int LAYER_W       = 5;

  // Each stream word carries this many biases, low half first.
  localparam int BIAS_PER_WORD = 2;

  // Loader controller states.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_IDLE = 3'd1,
    ST_SCALE     = 3'd2,
    ST_BIAS      = 3'd3,
    ST_DONE      = 3'd4
  } state_e;

endpackage

// File: rtl/pp_param_loader.sv
// Per-layer parameter loader for the postprocessor. After a start pulse it
// waits for the postprocessor to drain, pulls one scale word and the packed
// biases from the read stream, writes the biases one per cycle into the bias
// buffer and then flags the layer configuration as ready.
module pp_param_loader
  import pp_param_loader_pkg::*;
#(
  parameter int W_CHANNEL = PP_W_CHANNEL,
  parameter int BIAS_DW   = PP_BIAS_DW,
  parameter int SCALES_DW = PP_SCALES_DW,
  parameter int AXI_DW    = PP_AXI_DW
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 i_start,
  input  logic [LAYER_W-1:0]   i_q_layer,
  input  logic [W_CHANNEL-1:0] i_last_chn,
  input  logic                 i_pp_idle,
  input  logic [AXI_DW-1:0]    s_data,
  input  logic                 s_vld,
  output logic                 s_rdy,
  output logic                 o_bias_we,
  output logic [W_CHANNEL-1:0] o_bias_addr,
  output logic [BIAS_DW-1:0]   o_bias_wdata,
  output logic [SCALES_DW-1:0] o_scale,
  output logic [LAYER_W-1:0]   o_cfg_layer,
  output logic                 o_cfg_rdy,
  output logic                 o_busy,
  output logic                 o_done
);

  // Controller state and per-load context.
  state_e               state_q, state_d;
  logic [LAYER_W-1:0]   layer_q, layer_d;
  logic [W_CHANNEL-1:0] last_q, last_d;
  // Address of the next bias write.
  logic [W_CHANNEL-1:0] chn_q, chn_d;
  // High half of the word in the hold register still has to be written.
  logic                 hi_pend_q, hi_pend_d;
  // Final bias word of the layer has been accepted.
  logic                 all_acc_q, all_acc_d;
  logic [BIAS_DW-1:0]   hold_q, hold_d;

  // Registered outputs.
  logic                 bias_we_q, bias_we_d;
  logic [W_CHANNEL-1:0] bias_addr_q, bias_addr_d;
  logic [BIAS_DW-1:0]   bias_wdata_q, bias_wdata_d;
  logic [SCALES_DW-1:0] scale_q, scale_d;
  logic [LAYER_W-1:0]   cfg_layer_q, cfg_layer_d;
  logic                 cfg_rdy_q, cfg_rdy_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic                 last_wr;
  logic                 final_word;

  // The write currently on the bias port is the one for the last channel.
  assign last_wr = bias_we_q && (bias_addr_q == last_q);

  // A word whose low half lands on chn_q is the final one when its high half
  // reaches or passes the last channel.
  assign final_word = ({1'b0, chn_q} + (W_CHANNEL + 1)'(BIAS_PER_WORD - 1))
                      >= {1'b0, last_q};

  // Next-state, stream ready and bias write scheduling.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    layer_d      = layer_q;
    last_d       = last_q;
    chn_d        = chn_q;
    hi_pend_d    = hi_pend_q;
    all_acc_d    = all_acc_q;
    hold_d       = hold_q;
    bias_we_d    = 1'b0;
    bias_addr_d  = bias_addr_q;
    bias_wdata_d = bias_wdata_q;
    scale_d      = scale_q;
    cfg_layer_d  = cfg_layer_q;
    cfg_rdy_d    = cfg_rdy_q;
    s_rdy        = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          layer_d   = i_q_layer;
          last_d    = i_last_chn;
          cfg_rdy_d = 1'b0;
          chn_d     = '0;
          hi_pend_d = 1'b0;
          all_acc_d = 1'b0;
          state_d   = ST_WAIT_IDLE;
        end
      end

      ST_WAIT_IDLE: begin
        if (i_pp_idle) begin
          state_d = ST_SCALE;
        end
      end

      ST_SCALE: begin
        s_rdy = 1'b1;
        if (s_vld) begin
          scale_d = s_data[SCALES_DW-1:0];
          state_d = ST_BIAS;
        end
      end

      ST_BIAS: begin
        // Ready whenever the hold register is free: either empty or its high
        // half is on the bias port this cycle.
        s_rdy = !hi_pend_q && !all_acc_q;
        if (last_wr) begin
          // For an odd channel count this drops the unused high half.
          hi_pend_d = 1'b0;
          state_d   = ST_DONE;
        end else if (hi_pend_q) begin
          bias_we_d    = 1'b1;
          bias_addr_d  = chn_q;
          bias_wdata_d = hold_q;
          chn_d        = chn_q + 1'b1;
          hi_pend_d    = 1'b0;
        end else if (s_vld && s_rdy) begin
          bias_we_d    = 1'b1;
          bias_addr_d  = chn_q;
          bias_wdata_d = s_data[BIAS_DW-1:0];
          hold_d       = s_data[AXI_DW-1:BIAS_DW];
          chn_d        = chn_q + 1'b1;
          hi_pend_d    = 1'b1;
          if (final_word) begin
            all_acc_d = 1'b1;
          end
        end
      end

      ST_DONE: begin
        cfg_rdy_d   = 1'b1;
        cfg_layer_d = layer_q;
        state_d     = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // State, context and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: registers take non-blocking assignments so every flop samples the
    // pre-edge values regardless of statement order.
    if (!rstn) begin
      state_q      <= ST_IDLE;
      layer_q      <= '0;
      last_q       <= '0;
      chn_q        <= '0;
      hi_pend_q    <= 1'b0;
      all_acc_q    <= 1'b0;
      hold_q       <= '0;
      bias_we_q    <= 1'b0;
      bias_addr_q  <= '0;
      bias_wdata_q <= '0;
      scale_q      <= '0;
      cfg_layer_q  <= '0;
      cfg_rdy_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      layer_q      <= layer_d;
      last_q       <= last_d;
      chn_q        <= chn_d;
      hi_pend_q    <= hi_pend_d;
      all_acc_q    <= all_acc_d;
      hold_q       <= hold_d;
      bias_we_q    <= bias_we_d;
      bias_addr_q  <= bias_addr_d;
      bias_wdata_q <= bias_wdata_d;
      scale_q      <= scale_d;
      cfg_layer_q  <= cfg_layer_d;
      cfg_rdy_q    <= cfg_rdy_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign o_bias_we    = bias_we_q;
  assign o_bias_addr  = bias_addr_q;
  assign o_bias_wdata = bias_wdata_q;
  assign o_scale      = scale_q;
  assign o_cfg_layer  = cfg_layer_q;
  assign o_cfg_rdy    = cfg_rdy_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;

endmodule

// File: tb/tb_pp_param_loader.sv
// Bench for pp_param_loader: drives layer loads with a stream of scale and
// bias words, records every cycle, and scores the record against a model of
// the expected bias writes, handshake/write timing and status flags.
module tb_pp_param_loader;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        i_start = 1'b0;
  logic [4:0]  i_q_layer = '0;
  logic [9:0]  i_last_chn = '0;
  logic        i_pp_idle = 1'b0;
  logic [31:0] s_data = '0;
  logic        s_vld = 1'b0;
  logic        s_rdy;
  logic        o_bias_we;
  logic [9:0]  o_bias_addr;
  logic [15:0] o_bias_wdata;
  logic [31:0] o_scale;
  logic [4:0]  o_cfg_layer;
  logic        o_cfg_rdy;
  logic        o_busy;
  logic        o_done;

  pp_param_loader dut (
    .clk          (clk),
    .rstn         (rstn),
    .i_start      (i_start),
    .i_q_layer    (i_q_layer),
    .i_last_chn   (i_last_chn),
    .i_pp_idle    (i_pp_idle),
    .s_data       (s_data),
    .s_vld        (s_vld),
    .s_rdy        (s_rdy),
    .o_bias_we    (o_bias_we),
    .o_bias_addr  (o_bias_addr),
    .o_bias_wdata (o_bias_wdata),
    .o_scale      (o_scale),
    .o_cfg_layer  (o_cfg_layer),
    .o_cfg_rdy    (o_cfg_rdy),
    .o_busy       (o_busy),
    .o_done       (o_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic        hs;
    logic        rdy;
    logic        we;
    logic [9:0]  addr;
    logic [15:0] wdata;
    logic        done;
    logic        cfg_rdy;
    logic        busy;
    logic [4:0]  cfg_layer;
  } mon_t;

  mon_t        mon_q[$];
  logic [31:0] stream_q[$];

  // One record per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    mon_t m;
    m.hs        = s_vld && s_rdy;
    m.rdy       = s_rdy;
    m.we        = o_bias_we;
    m.addr      = o_bias_addr;
    m.wdata     = o_bias_wdata;
    m.done      = o_done;
    m.cfg_rdy   = o_cfg_rdy;
    m.busy      = o_busy;
    m.cfg_layer = o_cfg_layer;
    mon_q.push_back(m);
  end

  function automatic logic pick_vld(input int mode, input int cyc);
    case (mode)
      0:       return 1'b1;
      1:       return logic'((cyc % 2) == 0);
      default: return logic'($urandom_range(0, 1));
    endcase
  endfunction

  // Scale word followed by floor(last/2)+1 random bias words.
  task automatic fill_random(input logic [31:0] scale, input logic [9:0] last);
    stream_q.delete();
    stream_q.push_back(scale);
    for (int k = 0; k <= int'(last) / 2; k++) stream_q.push_back($urandom());
  endtask

  // Drive one load from the start pulse until the cycle after o_done.
  task automatic run_load(input logic [4:0] layer, input logic [9:0] last,
                          input int stall_mode, input int idle_delay,
                          input int busy_start_at);
    int idx;
    int cyc;
    bit done_seen;
    bit acc;
    idx = 0;
    cyc = 0;
    done_seen = 0;
    mon_q.delete();
    i_start    = 1'b1;
    i_q_layer  = layer;
    i_last_chn = last;
    i_pp_idle  = (idle_delay == 0);
    s_vld      = pick_vld(stall_mode, 0);
    s_data     = stream_q[0];
    while (!done_seen && cyc < 2000) begin
      @(negedge clk);
      acc = s_vld && s_rdy;
      done_seen = o_done;
      @(posedge clk);
      #1;
      if (acc) idx++;
      cyc++;
      i_start = (cyc == busy_start_at);
      if (i_start) begin
        i_q_layer  = ~layer;
        i_last_chn = ~last;
      end
      i_pp_idle = (cyc >= idle_delay);
      if (idx < stream_q.size()) begin
        s_vld  = pick_vld(stall_mode, cyc);
        s_data = s_vld ? stream_q[idx] : $urandom();
      end else begin
        s_vld  = 1'b1;
        s_data = 32'hDEAD_0000 | 32'(cyc);
      end
    end
    checks++;
    if (!done_seen) begin
      failures++;
      $display("FAIL load_timeout: o_done not seen within %0d cycles (layer %0d last %0d)",
               cyc, layer, last);
    end
    @(negedge clk);
    @(posedge clk);
    #1;
    s_vld   = 1'b0;
    i_start = 1'b0;
  endtask

  // Score the recorded load against the expected writes and flag timing.
  task automatic score_load(input string tag, input logic [4:0] layer,
                            input logic [9:0] last, input int stall_mode,
                            input int idle_delay);
    int ea[$];
    logic [15:0] ed[$];
    int oa[$];
    logic [15:0] od[$];
    int oc[$];
    int hs[$];
    int dn[$];
    int exp_a[];
    int nw, n, first_rdy, gate, bad, done_cyc, obs;
    logic [31:0] w;

    nw = int'(last) / 2 + 1;
    for (int k = 0; k < nw; k++) begin
      w = stream_q[k + 1];
      ea.push_back(2 * k);
      ed.push_back(w[15:0]);
      if (2 * k + 1 <= int'(last)) begin
        ea.push_back(2 * k + 1);
        ed.push_back(w[31:16]);
      end
    end

    n = mon_q.size();
    first_rdy = -1;
    foreach (mon_q[c]) begin
      if (mon_q[c].we) begin
        oa.push_back(int'(mon_q[c].addr));
        od.push_back(mon_q[c].wdata);
        oc.push_back(c);
      end
      if (mon_q[c].hs) hs.push_back(c);
      if (mon_q[c].done) dn.push_back(c);
      if (mon_q[c].rdy && first_rdy < 0) first_rdy = c;
    end

    checks++;
    if (oa.size() != ea.size()) begin
      failures++;
      $display("FAIL %s write_count: got %0d expected %0d", tag, oa.size(), ea.size());
    end
    for (int i = 0; i < ea.size() && i < oa.size(); i++) begin
      checks++;
      if (oa[i] != ea[i] || od[i] !== ed[i]) begin
        failures++;
        $display("FAIL %s write[%0d]: got addr %0d data %h expected addr %0d data %h",
                 tag, i, oa[i], od[i], ea[i], ed[i]);
      end
    end

    checks++;
    if (hs.size() != nw + 1) begin
      failures++;
      $display("FAIL %s accepted_words: got %0d expected %0d", tag, hs.size(), nw + 1);
    end

    // Each bias word accepted at cycle c writes low at c+1 and high at c+2.
    exp_a = new[n];
    foreach (exp_a[c]) exp_a[c] = -1;
    for (int k = 0; k < nw && k + 1 < hs.size(); k++) begin
      if (hs[k + 1] + 1 < n) exp_a[hs[k + 1] + 1] = 2 * k;
      if (2 * k + 1 <= int'(last) && hs[k + 1] + 2 < n) exp_a[hs[k + 1] + 2] = 2 * k + 1;
    end
    bad = 0;
    foreach (mon_q[c]) begin
      obs = mon_q[c].we ? int'(mon_q[c].addr) : -1;
      if (obs != exp_a[c]) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL %s write_timing: %0d cycles differ from accept-derived schedule", tag, bad);
    end

    gate = ((idle_delay < 1) ? 1 : idle_delay) + 1;
    checks++;
    if (first_rdy != gate) begin
      failures++;
      $display("FAIL %s first_s_rdy_cycle: got %0d expected %0d", tag, first_rdy, gate);
    end

    if (stall_mode == 0 && oc.size() > 0 && hs.size() > 0) begin
      checks++;
      if (oc[$] - oc[0] != oc.size() - 1) begin
        failures++;
        $display("FAIL %s write_gaps: span %0d for %0d writes", tag, oc[$] - oc[0], oc.size());
      end
      checks++;
      if (oc[0] != hs[0] + 2) begin
        failures++;
        $display("FAIL %s first_write_cycle: got %0d expected %0d", tag, oc[0], hs[0] + 2);
      end
    end

    checks++;
    if (dn.size() != 1) begin
      failures++;
      $display("FAIL %s done_pulses: got %0d expected 1", tag, dn.size());
    end
    if (dn.size() > 0) begin
      done_cyc = dn[0];
      if (oc.size() > 0) begin
        checks++;
        if (done_cyc != oc[$] + 1) begin
          failures++;
          $display("FAIL %s done_cycle: got %0d expected %0d", tag, done_cyc, oc[$] + 1);
        end
      end
      bad = 0;
      for (int c = 1; c <= done_cyc && c < n; c++) begin
        if (!mon_q[c].busy || mon_q[c].cfg_rdy) bad++;
      end
      checks++;
      if (bad != 0) begin
        failures++;
        $display("FAIL %s busy_cfg_rdy_during_load: %0d cycles wrong", tag, bad);
      end
      if (done_cyc + 1 < n) begin
        checks++;
        if ({mon_q[done_cyc + 1].cfg_rdy, mon_q[done_cyc + 1].busy, mon_q[done_cyc + 1].cfg_layer}
            !== {1'b1, 1'b0, layer}) begin
          failures++;
          $display("FAIL %s after_done: got cfg_rdy %b busy %b layer %0d expected 1 0 %0d",
                   tag, mon_q[done_cyc + 1].cfg_rdy, mon_q[done_cyc + 1].busy,
                   mon_q[done_cyc + 1].cfg_layer, layer);
        end
      end
    end

    checks++;
    if (o_scale !== stream_q[0]) begin
      failures++;
      $display("FAIL %s scale: got %h expected %h", tag, o_scale, stream_q[0]);
    end
  endtask

  task automatic test_reset();
    logic [67:0] rv;
    rstn   = 1'b0;
    s_vld  = 1'b1;
    s_data = 32'h1234_5678;
    repeat (3) @(posedge clk);
    #1;
    rv = {s_rdy, o_bias_we, o_bias_addr, o_bias_wdata, o_scale, o_cfg_layer,
          o_cfg_rdy, o_busy, o_done};
    checks++;
    if (rv !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got %h expected 0", rv);
    end
    @(negedge clk);
    rstn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({s_rdy, o_busy, o_cfg_rdy} !== 3'b000) begin
      failures++;
      $display("FAIL idle_no_accept: got rdy/busy/cfg_rdy %b expected 000", {s_rdy, o_busy, o_cfg_rdy});
    end
    s_vld = 1'b0;
  endtask

  task automatic test_load4();
    stream_q = '{32'h3F80_0000, 32'h0002_0001, 32'h0004_0003};
    run_load(5'd3, 10'd3, 0, 0, -1);
    score_load("load4", 5'd3, 10'd3, 0, 0);
  endtask

  task automatic test_odd_count();
    int bad;
    int nhs;
    stream_q = '{32'h4000_0000, 32'hBBBB_AAAA, 32'hDEAD_CCCC};
    run_load(5'd7, 10'd2, 0, 0, -1);
    score_load("odd", 5'd7, 10'd2, 0, 0);
    bad = 0;
    nhs = 0;
    foreach (mon_q[c]) begin
      if (mon_q[c].we && mon_q[c].wdata == 16'hDEAD) bad++;
      if (nhs >= 3 && mon_q[c].rdy) bad++;
      if (mon_q[c].hs) nhs++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL odd_discard_and_rdy: %0d offending cycles expected 0", bad);
    end
  endtask

  task automatic test_single_channel();
    stream_q = '{32'h0000_0001, 32'hFFFF_8001};
    run_load(5'd1, 10'd0, 0, 0, -1);
    score_load("last0", 5'd1, 10'd0, 0, 0);
  endtask

  task automatic test_idle_gating();
    fill_random($urandom(), 10'd5);
    run_load(5'd12, 10'd5, 0, 11, -1);
    score_load("idle_gate", 5'd12, 10'd5, 0, 11);
  endtask

  task automatic test_stalls();
    stream_q = '{32'h3F80_0000, 32'h0002_0001, 32'h0004_0003};
    run_load(5'd3, 10'd3, 1, 0, -1);
    score_load("stall_toggle", 5'd3, 10'd3, 1, 0);
    fill_random($urandom(), 10'd9);
    run_load(5'd9, 10'd9, 2, 2, -1);
    score_load("stall_random", 5'd9, 10'd9, 2, 2);
  endtask

  task automatic test_start_busy();
    fill_random($urandom(), 10'd5);
    run_load(5'd21, 10'd5, 0, 0, 6);
    score_load("start_busy", 5'd21, 10'd5, 0, 0);
  endtask

  task automatic test_reset_midload();
    logic [67:0] rv;
    int idx;
    int writes;
    bit acc;
    fill_random(32'hCAFE_F00D, 10'd7);
    idx = 0;
    writes = 0;
    i_start    = 1'b1;
    i_q_layer  = 5'd30;
    i_last_chn = 10'd7;
    i_pp_idle  = 1'b1;
    s_vld      = 1'b1;
    s_data     = stream_q[0];
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      acc = s_vld && s_rdy;
      if (o_bias_we) writes++;
      @(posedge clk);
      #1;
      i_start = 1'b0;
      if (acc) idx++;
      s_data = stream_q[idx];
    end
    checks++;
    if (writes < 1) begin
      failures++;
      $display("FAIL midload_progress: got %0d writes before reset expected >=1", writes);
    end
    #2;
    rstn = 1'b0;
    #1;
    rv = {s_rdy, o_bias_we, o_bias_addr, o_bias_wdata, o_scale, o_cfg_layer,
          o_cfg_rdy, o_busy, o_done};
    checks++;
    if (rv !== '0) begin
      failures++;
      $display("FAIL midload_reset_outputs: got %h expected 0", rv);
    end
    @(negedge clk);
    s_vld = 1'b0;
    rstn  = 1'b1;
    @(posedge clk);
    #1;
    fill_random($urandom(), 10'd6);
    run_load(5'd17, 10'd6, 0, 1, -1);
    score_load("reload", 5'd17, 10'd6, 0, 1);
  endtask

  task automatic test_random();
    logic [4:0] layer;
    logic [9:0] last;
    int mode;
    int dly;
    for (int t = 0; t < 6; t++) begin
      layer = 5'($urandom());
      last  = 10'($urandom_range(0, 40));
      mode  = $urandom_range(0, 2);
      dly   = $urandom_range(0, 5);
      fill_random($urandom(), last);
      run_load(layer, last, mode, dly, -1);
      score_load("random", layer, last, mode, dly);
    end
  endtask

  initial begin
    test_reset();
    test_load4();
    test_odd_count();
    test_single_channel();
    test_idle_gating();
    test_stalls();
    test_start_busy();
    test_reset_midload();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
